pattern_det_ctrl: RTL and testbench

Programmable serial pattern-detector controller. It takes a pattern configuration (bits, length, overlap mode, target count) through a handshake. It then sequences a run over a gated serial bit stream, pulses on each match and counts matches. It signals completion when the target count is reached. It sits in front of the FSM sequence-detector blocks and replaces per-pattern hardcoded detectors with one configurable engine.

---
 rtl/pattern_det_if.sv | 34 +++
 rtl/pattern_det_ctrl.sv | 129 ++++++++++++
 tb/tb_pattern_det_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_det_if.sv
// Configuration, control and serial-stream bundle for pattern_det_ctrl.
// The master side drives configuration and data; the slave side is the detector.
interface pattern_det_if #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8
);
  logic                           cfg_valid;
  logic                           cfg_ready;
  logic [MAXLEN-1:0]              cfg_pattern;
  logic [$clog2(MAXLEN+1)-1:0]    cfg_len;
  logic                           cfg_overlap;
  logic [CNT_W-1:0]               cfg_target;
  logic                           start;
  logic                           abort;
  logic                           done_ack;
  logic                           data_valid;
  logic                           data;
  logic                           detected;
  logic [CNT_W-1:0]               match_count;
  logic                           busy;
  logic                           done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, done_ack, data_valid, data,
    input  cfg_ready, detected, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, done_ack, data_valid, data,
    output cfg_ready, detected, match_count, busy, done
  );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Programmable serial pattern detector: latches a pattern configuration, runs over a
// gated bit stream, pulses on each match, counts matches and stops at a target count.
module pattern_det_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           rst,
  pattern_det_if.slave  bus
);
  localparam int               LEN_W   = $clog2(MAXLEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAXLEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;

  logic [MAXLEN-1:0] pat_q;
  logic [LEN_W-1:0]  len_q;
  logic              ovl_q;
  logic [CNT_W-1:0]  tgt_q;

  // The oldest history bit is never compared after a shift, so only MAXLEN-1 bits are kept.
  logic [MAXLEN-2:0] hist_q;
  logic [MAXLEN-1:0] hist_nxt;
  logic [MAXLEN-1:0] len_mask;
  logic [LEN_W-1:0]  fill_q, fill_nxt;
  logic [LEN_W-1:0]  cfg_len_clamped;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic              det_q;

  logic              cfg_fire;
  logic              run_start;
  logic              shift_en;
  logic              hit;
  logic              match;
  logic              reach_target;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort outranks a match, done_ack and start.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (run_start) state_nxt = RUN;
      RUN: begin
        if (bus.abort)         state_nxt = IDLE;
        else if (reach_target) state_nxt = DONE;
      end
      DONE: if (bus.abort || bus.done_ack) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    bus.cfg_ready   = (state == IDLE);
    bus.busy        = (state == RUN);
    bus.done        = (state == DONE);
    bus.detected    = det_q;
    bus.match_count = cnt_q;
  end

  // Match datapath.
  always_comb begin
    cfg_fire  = bus.cfg_valid && (state == IDLE);
    run_start = (state == IDLE) && bus.start && !bus.abort;
    shift_en  = (state == RUN) && bus.data_valid && !bus.abort;

    if (bus.cfg_len == '0)          cfg_len_clamped = LEN_ONE;
    else if (bus.cfg_len > LEN_MAX) cfg_len_clamped = LEN_MAX;
    else                            cfg_len_clamped = bus.cfg_len;

    hist_nxt = {hist_q, bus.data};
    fill_nxt = (fill_q >= len_q) ? len_q : fill_q + LEN_ONE;

    len_mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end

    hit          = (fill_nxt >= len_q) && (((hist_nxt ^ pat_q) & len_mask) == '0);
    match        = shift_en && hit;
    cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    reach_target = match && (tgt_q != '0) && (cnt_inc == tgt_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: history is a plain register rather than a memory array, so it resets with
    // the rest of the state and a restart never sees stale bits.
    if (rst) begin
      pat_q  <= '0;
      len_q  <= LEN_ONE;
      ovl_q  <= 1'b0;
      tgt_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      det_q  <= 1'b0;
    end else begin
      det_q <= match;
      if (cfg_fire) begin
        pat_q <= bus.cfg_pattern;
        len_q <= cfg_len_clamped;
        ovl_q <= bus.cfg_overlap;
        tgt_q <= bus.cfg_target;
      end
      if (run_start) begin
        hist_q <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
      end else if (shift_en) begin
        hist_q <= hist_nxt[MAXLEN-2:0];
        // Non-overlapping mode demands a full set of fresh bits after each match.
        fill_q <= (match && !ovl_q) ? '0 : fill_nxt;
        if (match) cnt_q <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed bench for pattern_det_ctrl: a bit-window model checked every cycle,
// plus literal per-scenario expectations that pin the model itself.
module tb_pattern_det_ctrl;
  localparam int MAXLEN = 8;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst;

  pattern_det_if #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) bus ();

  pattern_det_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int det_pulses = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the run is idle, running or finished; a window of received bits is
  // compared as a number against the low len bits of the pattern.
  bit m_busy, m_done, m_det, m_ovl;
  int m_count, m_len, m_tgt, m_pat;
  bit m_win[$];

  function automatic int win_value();
    int v = 0;
    foreach (m_win[i]) v = v * 2 + int'(m_win[i]);
    return v;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_done = 0; m_det = 0; m_ovl = 0;
      m_count = 0; m_len = 1; m_tgt = 0; m_pat = 0;
      m_win.delete();
      return;
    end
    m_det = 0;
    if (!m_busy && !m_done) begin
      if (bus.cfg_valid) begin
        m_pat = int'(bus.cfg_pattern);
        m_len = (bus.cfg_len == 0) ? 1 : (bus.cfg_len > MAXLEN) ? MAXLEN : int'(bus.cfg_len);
        m_ovl = bus.cfg_overlap;
        m_tgt = int'(bus.cfg_target);
      end
      if (bus.start && !bus.abort) begin
        m_busy = 1; m_count = 0; m_win.delete();
      end
    end else if (bus.abort) begin
      m_busy = 0; m_done = 0;
    end else if (m_busy) begin
      if (bus.data_valid) begin
        m_win.push_back(bus.data);
        if (m_win.size() > m_len) void'(m_win.pop_front());
        if (m_win.size() == m_len && win_value() == (m_pat % (1 << m_len))) begin
          m_det = 1;
          if (m_count < (1 << CNT_W) - 1) m_count++;
          if (!m_ovl) m_win.delete();
          if (m_tgt != 0 && m_count == m_tgt) begin
            m_busy = 0; m_done = 1;
          end
        end
      end
    end else if (bus.done_ack) begin
      m_done = 0;
    end
  endtask

  // Compare process: outputs are registered, so mid-cycle is a stable sample point.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("detected",    bus.detected,    int'(m_det));
      check("match_count", bus.match_count, m_count);
      check("busy",        bus.busy,        int'(m_busy));
      check("done",        bus.done,        int'(m_done));
      check("cfg_ready",   bus.cfg_ready,   int'(!m_busy && !m_done));
      if (bus.detected) det_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input int len, input bit ovl,
                           input int tgt, input bit with_start);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len[3:0];
    bus.cfg_overlap = ovl;
    bus.cfg_target  = tgt[7:0];
    bus.start       = with_start;
    tick();
    bus.cfg_valid   = 1'b0;
    bus.start       = 1'b0;
  endtask

  task automatic run_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  // Sends bits[n-1] first; with gap a data_valid=0 cycle follows every bit.
  task automatic send_bits(input logic [15:0] bits, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      bus.data_valid = 1'b1;
      bus.data       = bits[i];
      tick();
      bus.data_valid = 1'b0;
      bus.data       = 1'b0;
      if (gap) tick();
    end
  endtask

  initial begin
    bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.cfg_target = '0; bus.start = 0; bus.abort = 0; bus.done_ack = 0;
    bus.data_valid = 0; bus.data = 0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_busy",      bus.busy, 0);
    check("rst_done",      bus.done, 0);
    check("rst_detected",  bus.detected, 0);
    check("rst_count",     bus.match_count, 0);
    rst = 1'b0;
    tick();

    // Non-overlapping 1010 over 10101010
    configure(8'b1010, 4, 0, 0, 0);
    run_start();
    det_pulses = 0;
    send_bits(16'b1010_1010, 8, 0);
    tick();
    check("s2_pulses",    det_pulses, 2);
    check("s2_count",     bus.match_count, 2);
    check("s2_model_cnt", m_count, 2);
    do_abort();
    check("s2_abort_idle", bus.cfg_ready, 1);
    check("s2_count_held", bus.match_count, 2);

    // Overlapping 1010 over the same stream
    configure(8'b1010, 4, 1, 0, 0);
    run_start();
    det_pulses = 0;
    send_bits(16'b1010_1010, 8, 0);
    tick();
    check("s3_pulses",    det_pulses, 3);
    check("s3_count",     bus.match_count, 3);
    check("s3_model_cnt", m_count, 3);
    do_abort();

    // Target of 3 with overlapping 11
    configure(8'b11, 2, 1, 3, 0);
    run_start();
    det_pulses = 0;
    send_bits(16'b1111, 4, 0);
    check("s4_done",  bus.done, 1);
    check("s4_count", bus.match_count, 3);
    send_bits(16'b1, 1, 0);
    check("s4_pulses",        det_pulses, 3);
    check("s4_count_ignored", bus.match_count, 3);
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
    check("s4_ack_ready", bus.cfg_ready, 1);
    check("s4_ack_done",  bus.done, 0);
    check("s4_ack_count", bus.match_count, 3);

    // Gapped stream, then abort on the completing bit
    configure(8'b1010, 4, 0, 0, 0);
    run_start();
    det_pulses = 0;
    send_bits(16'b1010_1010, 8, 1);
    check("s5_pulses", det_pulses, 2);
    check("s5_count",  bus.match_count, 2);
    do_abort();
    run_start();
    det_pulses = 0;
    send_bits(16'b101, 3, 0);
    bus.data_valid = 1'b1; bus.data = 1'b0; bus.abort = 1'b1;
    tick();
    bus.data_valid = 1'b0; bus.abort = 1'b0;
    check("s5_abort_busy", bus.busy, 0);
    check("s5_abort_det",  bus.detected, 0);
    tick();
    check("s5_abort_pulses", det_pulses, 0);
    check("s5_abort_count",  bus.match_count, 0);

    // cfg_len=0 stored as 1
    configure(8'b1, 0, 0, 0, 0);
    run_start();
    det_pulses = 0;
    send_bits(16'b11, 2, 0);
    tick();
    check("s6_len0_pulses", det_pulses, 2);
    check("s6_len0_count",  bus.match_count, 2);
    do_abort();

    // cfg_len=15 clamped to 8
    configure(8'b1011_0011, 15, 0, 0, 0);
    run_start();
    det_pulses = 0;
    send_bits(16'b01_1011_0011, 10, 0);
    tick();
    check("s6_len15_pulses", det_pulses, 1);
    check("s6_len15_model",  m_count, 1);
    do_abort();

    // cfg handshake and start in the same cycle
    configure(8'b01, 2, 0, 0, 1);
    check("s6_same_busy", bus.busy, 1);
    det_pulses = 0;
    send_bits(16'b01, 2, 0);
    tick();
    check("s6_same_pulses", det_pulses, 1);
    check("s6_same_count",  bus.match_count, 1);
    do_abort();

    // Reset mid-run also restores the stored config (pattern 0, len 1)
    configure(8'b11, 2, 1, 0, 0);
    run_start();
    send_bits(16'b11, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s7_rst_busy",  bus.busy, 0);
    check("s7_rst_count", bus.match_count, 0);
    run_start();
    det_pulses = 0;
    send_bits(16'b0, 1, 0);
    tick();
    check("s7_default_pulses", det_pulses, 1);
    check("s7_default_count",  bus.match_count, 1);
    do_abort();
    tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
